add_sub_serial_ctrl_16bit: RTL
==============================

# add_sub_serial_ctrl_16bit

Sequencing controller that performs 16-bit add/subtract by time-multiplexing a single 4-bit ripple-carry add/sub slice over four nibble cycles, least-significant nibble first. It sits between a requester using a start/busy/done handshake and the shared 4-bit slice. The slice uses XOR-on-b with mode M plus carry-in, with full-adder cells. The controller owns operand latching, nibble selection, inter-nibble carry storage, mode/carry-in configuration and flag generation.

## Interface
- N_NIB, 4, number of 4-bit nibbles per operand; operand width W = 4*N_NIB. All values below assume the default of 4.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  1  0 = add (a+b), 1 = subtract (a-b); latched at accept.
- a  in  16  operand A; latched at accept.
- b  in  16  operand B; latched at accept.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse; results valid from this cycle on.
- sum  out  16  result, modulo 2^16.
- c_out  out  1  final carry out of nibble 3. For subtract, 1 = no borrow (a >= b unsigned).
- ovf  out  1  two's-complement overflow.
- zero  out  1  sum == 0.

## Operation
- FSM states:
  - IDLE: busy=0; waiting for a request.
  - RUN: busy=1; nibble index idx runs 0..3.
- Accept:
  - At the edge where state=IDLE and start=1:
    - latch a, b and op;
    - set the carry register to op (forced carry-in of 1 for subtract);
    - set idx to 0, state to RUN, busy to 1.
- Per RUN edge:
  - The slice receives a[4*idx+3:4*idx], b[4*idx+3:4*idx], M=op and c_in=carry register.
  - Store the slice's 4-bit sum into an internal staging register at nibble idx.
  - Store the slice's carry out into the carry register.
  - Increment idx.
- Final edge (idx=3):
  - sum <= staging register with nibble 3 merged;
  - c_out <= slice carry out;
  - ovf <= (a[15] == b[15]^op) && (new sum[15] != a[15]);
  - zero <= (new sum == 0);
  - done <= 1, busy <= 0, state <= IDLE.
- sum, c_out, ovf and zero change only on a final edge. They hold their values until the next operation completes.
- start while busy=1 is ignored. Requests are not queued, and latched operands are not disturbed.
- Changes to a, b or op after accept have no effect.
- No other ports drive the slice. In IDLE the slice inputs are don't-care.

## Timing
- Reset values (next edge with reset=1): state=IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, zero=0, idx=0, carry register=0.
- Reset during RUN aborts the operation. No done pulse is produced, and the partial result is discarded.
- Reset has priority over start.
- Latency: accept at edge E0, nibbles processed at edges E1..E4.
  - done=1 and results valid in the cycle after E4.
  - busy=1 during the cycles following E0..E3.
- done is high for exactly one cycle, then returns low unless a new completion occurs.
- Back-to-back operation: busy=0 after E4, so start can be accepted at E5 while done is high. The next done follows at E9.
- Throughput: one operation per 5 cycles.
- Carry ripples combinationally within one nibble only. The inter-nibble carry is registered, so the critical path is one 4-bit slice.

## Test plan
- Basic add: add 0x1234 + 0x0FFF -> done 4 cycles after accept; sum=0x2233, c_out=0, ovf=0, zero=0.
- Add with wrap-around: add 0xFFFF + 0x0001 -> sum=0x0000, c_out=1, zero=1, ovf=0. Then add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, c_out=0.
- Subtract with borrow and with overflow:
  - sub 0x0005 - 0x0007 -> sum=0xFFFE, c_out=0, ovf=0.
  - sub 0x8000 - 0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
  - sub 0x1234 - 0x1234 -> sum=0, zero=1, c_out=1.
- Busy protection: accept add 0x0001 + 0x0001. Assert start with a=0xFFFF, b=0xFFFF, op=1 during busy and change the a/b inputs mid-op -> single done, sum=0x0002; the second request is not executed.
- Back-to-back: hold start=1 continuously with alternating operands -> accepts every 5 cycles, done pulses every 5 cycles, each sum correct.
- Reset mid-operation: assert reset at E2 of 0xFFFF + 0x0001 -> next cycle busy=0, done=0, sum=0, c_out=0. No done pulse follows. A subsequent add 0x0003 + 0x0004 gives sum=0x0007.

Source files
------------

// File: rtl/add_sub_serial_ctrl_16bit.sv
// ============================================================================
// Module   : add_sub_serial_ctrl_16bit (with add_sub_slice4)
// Brief    : 16-bit add/subtract sequenced over a shared 4-bit ripple slice,
//            one nibble per cycle, LSB nibble first, start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module add_sub_slice4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       m_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);

  logic [4:0] w_c;
  logic [3:0] w_bx;

  assign w_c[0] = c_i;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_fa
      assign w_bx[k]   = b_i[k] ^ m_i;
      assign s_o[k]    = a_i[k] ^ w_bx[k] ^ w_c[k];
      assign w_c[k+1]  = (a_i[k] & w_bx[k]) | (w_c[k] & (a_i[k] ^ w_bx[k]));
    end
  endgenerate

  assign c_o = w_c[4];

endmodule

module add_sub_serial_ctrl_16bit #(
  parameter int N_NIB = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 op_i,
  input  logic [4*N_NIB-1:0]   a_i,
  input  logic [4*N_NIB-1:0]   b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*N_NIB-1:0]   sum_o,
  output logic                 c_out_o,
  output logic                 ovf_o,
  output logic                 zero_o
);

  localparam int W    = 4 * N_NIB;
  localparam int IDXW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NIB - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            op_q, op_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    stage_q, stage_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_s_nib;
  logic            w_c_nib;
  logic [W-1:0]    w_merged;

  // Nibble select mux feeding the shared slice; values in IDLE are unused.
  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    for (int n = 0; n < N_NIB; n++) begin
      if (idx_q == IDXW'(n)) begin
        w_a_nib = a_q[4*n +: 4];
        w_b_nib = b_q[4*n +: 4];
      end
    end
  end

  add_sub_slice4 u_slice (
    .a_i (w_a_nib),
    .b_i (w_b_nib),
    .m_i (op_q),
    .c_i (carry_q),
    .s_o (w_s_nib),
    .c_o (w_c_nib)
  );

  always_comb begin
    w_merged = stage_q;
    for (int n = 0; n < N_NIB; n++) begin
      if (idx_q == IDXW'(n)) begin
        w_merged[4*n +: 4] = w_s_nib;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    stage_d = stage_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_i;
          carry_d = op_i;  // subtract = a + ~b + 1
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        stage_d = w_merged;
        carry_d = w_c_nib;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d   = w_merged;
          c_out_d = w_c_nib;
          ovf_d   = (a_q[W-1] == (b_q[W-1] ^ op_q)) && (w_merged[W-1] != a_q[W-1]);
          zero_d  = (w_merged == '0);
          done_d  = 1'b1;
          idx_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      stage_q <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      stage_q <= stage_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;
  assign sum_o   = sum_q;
  assign c_out_o = c_out_q;
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule

`default_nettype wire
